seq_signed_divider: RTL and testbench
=====================================

// Module: seq_signed_divider
// PURPOSE
//  Sequential two's-complement divider. Inverse of the Baugh-Wooley array multiplier.
//  Takes a signed dividend and divisor and returns signed quotient and remainder.
//  Uses WIDTH restoring iterations on operand magnitudes, then a sign-fix step.
//  Sits next to the multiplier in the arithmetic unit; start/done handshake to the controller.
// PARAMETERS
//  WIDTH  4  operand/result width in bits (>=2); all values two's complement
// PORTS
//  clk          in   1      single clock, rising edge
//  rst_n        in   1      asynchronous, active-low reset
//  start        in   1      request; sampled only when busy=0
//  dividend     in   WIDTH  signed dividend, captured on accepted start
//  divisor      in   WIDTH  signed divisor, captured on accepted start
//  busy         out  1      operation in progress; start ignored while high
//  done         out  1      one-cycle pulse; results valid from this cycle
//  quotient     out  WIDTH  signed quotient, truncated toward zero
//  remainder    out  WIDTH  signed remainder; sign follows the dividend (or 0)
//  div_by_zero  out  1      divisor was 0 for the last completed operation
//  overflow     out  1      dividend=-2^(WIDTH-1) and divisor=-1
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - state=IDLE; busy, done, div_by_zero, overflow = 0.
//   - quotient and remainder = 0.
//   - Reset mid-operation aborts it: no done pulse; outputs are cleared.
//  States:
//   - IDLE: busy=0. start=1 at edge k latches operands and goes to RUN.
//     If divisor==0, goes straight to DONE instead.
//   - RUN: busy=1. Internal state: |dividend| and |divisor| magnitudes, a WIDTH+1-bit
//     partial remainder, and a bit counter.
//     One restoring step per edge: shift, trial subtract, restore if negative,
//     set one quotient bit. Runs for exactly WIDTH edges (k+1..k+WIDTH).
//   - Edge k+WIDTH+1: sign fix; quotient/remainder/flags registered; go to DONE.
//   - DONE: done=1, busy=0 for exactly one cycle. Otherwise behaves as IDLE:
//     start in this cycle is accepted. No start returns the block to IDLE.
//  Latency:
//   - Normal: done is high in the cycle after edge k+WIDTH+1.
//   - Divide by zero: done is high in the cycle after edge k+1.
//  Sign rules:
//   - Quotient is negative iff operand signs differ and the magnitude quotient is nonzero.
//   - Remainder is negated iff the dividend is negative.
//   - Magnitude of -2^(WIDTH-1) is handled in WIDTH+1 bits internally.
//  Divide by zero: quotient = all ones (-1), remainder = dividend, div_by_zero=1.
//  Overflow case (-2^(WIDTH-1) / -1): quotient = -2^(WIDTH-1) (wrap), remainder=0,
//   overflow=1, normal latency.
//  Flags are set only for the operation that raised them. They are cleared when the
//   next operation completes.
//  Outputs hold their last result until the next completion or reset; they never
//   change while busy=1.
//  start while busy=1 is ignored: no queuing, no effect on the current operation.
//  Operand inputs may change freely after an accepted start.
// TESTING (WIDTH=4)
//  1. 7/2 -> quotient=3, remainder=1, flags 0.
//     done high exactly in the cycle after edge k+5; busy high for 5 cycles.
//  2. Sign combinations:
//     -7/2  -> q=4'b1101 (-3), r=4'b1111 (-1)
//     7/-2  -> q=-3, r=1
//     -7/-2 -> q=3, r=-1
//     -1/4  -> q=0, r=-1
//  3. -8/-1 -> q=4'b1000, r=0, overflow=1.
//     Then -8/1 -> q=-8, r=0, overflow=0.
//  4. 5/0 -> q=4'b1111, r=5, div_by_zero=1, done in the cycle after edge k+1.
//     Next op 6/3 -> q=2, r=0, div_by_zero=0.
//  5. Start 6/3; pulse start with 1/1 at k+2 -> ignored, result is q=2, r=0.
//     Then start 3/2 in the done cycle -> accepted, q=1, r=1.
//  6. rst_n low at k+3 of 7/2 -> all outputs 0 immediately, no done pulse.
//     After release, 7/2 completes normally.
//  Plus an exhaustive sweep of all 256 operand pairs against a $signed reference model.

Source files
------------

// File: rtl/seq_signed_divider.sv
`default_nettype none
// ============================================================================
//  Module   : seq_signed_divider
//  Purpose  : Sequential two's-complement divider. Restoring division on the
//             operand magnitudes (one quotient bit per clock), followed by a
//             registered sign-fix step. Start/done handshake to the controller.
//  Revision : 1.0 - initial release
// ============================================================================
module seq_signed_divider #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             overflow
);

    // Step counter is wide enough to hold WIDTH-1
    localparam int                 c_CNT_W    = $clog2(WIDTH) + 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(WIDTH - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = {{(c_CNT_W-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0]   c_ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0]   c_MIN      = {1'b1, {(WIDTH-1){1'b0}}};

    // FIX is the single registered sign-fix cycle; divide-by-zero also
    // passes through it so its result is registered the same way
    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_FIX  = 2'd2;
    localparam logic [1:0] c_DONE = 2'd3;

    logic [1:0]         r_state;
    logic [1:0]         w_next_state;

    logic [WIDTH-1:0]   r_dividend;   // raw dividend: sign and div-by-zero remainder
    logic               r_dvs_neg;    // divisor sign
    logic [WIDTH-1:0]   r_b;          // |divisor|
    logic [WIDTH-1:0]   r_q;          // |dividend| shifting out, quotient bits shifting in
    logic [WIDTH-1:0]   r_r;          // partial remainder (always < |divisor|)
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_dz_pend;
    logic               r_ovf_pend;

    logic               r_done;
    logic [WIDTH-1:0]   r_quotient;
    logic [WIDTH-1:0]   r_remainder;
    logic               r_div_by_zero;
    logic               r_overflow;

    logic               w_accept;
    logic [WIDTH:0]     w_rsh;
    logic [WIDTH:0]     w_diff;
    logic               w_q_neg;
    logic [WIDTH-1:0]   w_qfix;
    logic [WIDTH-1:0]   w_rfix;

    // Start is honoured only when idle or in the done cycle
    assign w_accept = start && ((r_state == c_IDLE) || (r_state == c_DONE));

    // Shifted partial remainder fits in WIDTH+1 bits; bit WIDTH of the trial
    // difference is set exactly when the subtraction went negative
    assign w_rsh  = {r_r, r_q[WIDTH-1]};
    assign w_diff = w_rsh - {1'b0, r_b};

    // Sign fix: a zero magnitude quotient stays zero; |-2^(W-1)| wraps back
    assign w_q_neg = (r_dividend[WIDTH-1] ^ r_dvs_neg) && (r_q != '0);
    assign w_qfix  = w_q_neg ? (~r_q + c_ONE) : r_q;
    assign w_rfix  = r_dividend[WIDTH-1] ? (~r_r + c_ONE) : r_r;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE, c_DONE: begin
                if (start) begin
                    w_next_state = (divisor == '0) ? c_FIX : c_RUN;
                end else begin
                    w_next_state = c_IDLE;
                end
            end
            c_RUN: begin
                if (r_cnt == c_CNT_LAST) begin
                    w_next_state = c_FIX;
                end
            end
            c_FIX:   w_next_state = c_DONE;
            default: w_next_state = c_IDLE;
        endcase
    end

    // Operand capture and one restoring step per clock while running
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dividend <= '0;
            r_dvs_neg  <= 1'b0;
            r_b        <= '0;
            r_q        <= '0;
            r_r        <= '0;
            r_cnt      <= '0;
            r_dz_pend  <= 1'b0;
            r_ovf_pend <= 1'b0;
        end else if (w_accept) begin
            r_dividend <= dividend;
            r_dvs_neg  <= divisor[WIDTH-1];
            r_b        <= divisor[WIDTH-1] ? (~divisor + c_ONE) : divisor;
            r_q        <= dividend[WIDTH-1] ? (~dividend + c_ONE) : dividend;
            r_r        <= '0;
            r_cnt      <= '0;
            r_dz_pend  <= (divisor == '0);
            r_ovf_pend <= (dividend == c_MIN) && (divisor == '1);
        end else if (r_state == c_RUN) begin
            r_r   <= w_diff[WIDTH] ? w_rsh[WIDTH-1:0] : w_diff[WIDTH-1:0];
            r_q   <= {r_q[WIDTH-2:0], ~w_diff[WIDTH]};
            r_cnt <= r_cnt + c_CNT_ONE;
        end
    end

    // Result registers: written only in the fix cycle, held otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_quotient    <= '0;
            r_remainder   <= '0;
            r_div_by_zero <= 1'b0;
            r_overflow    <= 1'b0;
        end else if (r_state == c_FIX) begin
            if (r_dz_pend) begin
                r_quotient    <= '1;
                r_remainder   <= r_dividend;
                r_div_by_zero <= 1'b1;
                r_overflow    <= 1'b0;
            end else begin
                r_quotient    <= w_qfix;
                r_remainder   <= w_rfix;
                r_div_by_zero <= 1'b0;
                r_overflow    <= r_ovf_pend;
            end
        end
    end

    // Done pulse registered alongside the results
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_done <= 1'b0;
        end else begin
            r_done <= (r_state == c_FIX);
        end
    end

    assign busy        = (r_state == c_RUN) || (r_state == c_FIX);
    assign done        = r_done;
    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign div_by_zero = r_div_by_zero;
    assign overflow    = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_seq_signed_divider.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seq_signed_divider
//  Purpose  : Self-checking bench for seq_signed_divider (WIDTH=4): directed
//             vector table, handshake corner sequences, exhaustive sweep.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_seq_signed_divider;

    localparam int c_W = 4;

    typedef struct {
        logic [c_W-1:0] a;
        logic [c_W-1:0] b;
        logic [c_W-1:0] q;
        logic [c_W-1:0] r;
        logic           dz;
        logic           ovf;
        int             lat;
    } vec_t;

    typedef struct {
        logic [c_W-1:0] a;
        logic [c_W-1:0] b;
        logic [c_W-1:0] q;
        logic [c_W-1:0] r;
        logic           dz;
        logic           ovf;
    } exp_t;

    logic           clk;
    logic           rst_n;
    logic           start;
    logic [c_W-1:0] dividend;
    logic [c_W-1:0] divisor;
    logic           busy;
    logic           done;
    logic [c_W-1:0] quotient;
    logic [c_W-1:0] remainder;
    logic           div_by_zero;
    logic           overflow;

    int   n_vec;
    int   n_bad;
    exp_t sb[$];

    seq_signed_divider #(.WIDTH(c_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference result from integer signed division (truncating toward zero)
    function automatic exp_t model(input logic [c_W-1:0] a, input logic [c_W-1:0] b);
        exp_t e;
        int   ia;
        int   ib;
        int   iq;
        int   ir;
        e.a = a;
        e.b = b;
        if (b == '0) begin
            e.q   = '1;
            e.r   = a;
            e.dz  = 1'b1;
            e.ovf = 1'b0;
        end else begin
            ia    = int'($signed(a));
            ib    = int'($signed(b));
            iq    = ia / ib;
            ir    = ia % ib;
            e.q   = iq[c_W-1:0];
            e.r   = ir[c_W-1:0];
            e.dz  = 1'b0;
            e.ovf = (ia == -(1 << (c_W - 1))) && (ib == -1);
        end
        return e;
    endfunction

    task automatic check(input string name, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Scoreboard: every done pulse pops one expectation and compares results
    always @(negedge clk) begin
        if (rst_n && done) begin
            n_vec++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_done: q=%h r=%h dz=%b ovf=%b with nothing outstanding",
                         quotient, remainder, div_by_zero, overflow);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (quotient !== e.q || remainder !== e.r ||
                    div_by_zero !== e.dz || overflow !== e.ovf) begin
                    n_bad++;
                    $display("FAIL result %h/%h: got q=%h r=%h dz=%b ovf=%b, expected q=%h r=%h dz=%b ovf=%b",
                             e.a, e.b, quotient, remainder, div_by_zero, overflow,
                             e.q, e.r, e.dz, e.ovf);
                end
            end
        end
    end

    // Waits (bounded) for done after the accept edge; returns cycles after
    // the accept edge and the number of sampled cycles with busy high
    task automatic wait_done(output int lat, output int bcnt);
        lat  = -1;
        bcnt = busy ? 1 : 0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = n;
                break;
            end
            if (busy) bcnt++;
        end
    endtask

    // Issue one operation; exp_lat < 0 skips the latency/busy checks
    task automatic run_op(input logic [c_W-1:0] a, input logic [c_W-1:0] b,
                          input exp_t e, input int exp_lat);
        int lat;
        int bcnt;
        @(negedge clk);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        sb.push_back(e);
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = $urandom_range(0, 15);
        divisor  = $urandom_range(0, 15);
        wait_done(lat, bcnt);
        if (lat < 0) begin
            check("done_timeout", lat, exp_lat);
            sb.delete();
        end else if (exp_lat > 0) begin
            check("latency", lat, exp_lat);
            if (exp_lat == c_W + 1) check("busy_cycles", bcnt, c_W + 1);
        end
    endtask

    vec_t tbl[9];

    initial begin
        int   lat;
        int   bcnt;
        exp_t e;

        n_vec = 0;
        n_bad = 0;

        tbl[0] = '{4'd7,    4'd2,    4'd3,    4'd1,    1'b0, 1'b0, 5};
        tbl[1] = '{4'b1001, 4'd2,    4'b1101, 4'b1111, 1'b0, 1'b0, 5};
        tbl[2] = '{4'd7,    4'b1110, 4'b1101, 4'd1,    1'b0, 1'b0, 5};
        tbl[3] = '{4'b1001, 4'b1110, 4'd3,    4'b1111, 1'b0, 1'b0, 5};
        tbl[4] = '{4'b1111, 4'd4,    4'd0,    4'b1111, 1'b0, 1'b0, 5};
        tbl[5] = '{4'b1000, 4'b1111, 4'b1000, 4'd0,    1'b0, 1'b1, 5};
        tbl[6] = '{4'b1000, 4'd1,    4'b1000, 4'd0,    1'b0, 1'b0, 5};
        tbl[7] = '{4'd5,    4'd0,    4'b1111, 4'd5,    1'b1, 1'b0, 1};
        tbl[8] = '{4'd6,    4'd3,    4'd2,    4'd0,    1'b0, 1'b0, 5};

        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_quotient", int'(quotient), 0);
        check("reset_remainder", int'(remainder), 0);
        check("reset_flags", int'({div_by_zero, overflow}), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table
        for (int i = 0; i < 9; i++) begin
            e = '{tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].r, tbl[i].dz, tbl[i].ovf};
            run_op(tbl[i].a, tbl[i].b, e, tbl[i].lat);
        end

        // Done is a single-cycle pulse and the block returns to idle
        @(posedge clk);
        #1;
        check("done_width", int'(done), 0);
        check("idle_busy", int'(busy), 0);
        check("hold_quotient", int'(quotient), 2);

        // Start while busy is ignored; start in the done cycle is accepted
        @(negedge clk);
        start    = 1'b1;
        dividend = 4'd6;
        divisor  = 4'd3;
        sb.push_back(model(4'd6, 4'd3));
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        start    = 1'b1;
        dividend = 4'd1;
        divisor  = 4'd1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("hold_while_busy", int'(quotient), 2);
        wait_done(lat, bcnt);
        check("ignored_start_latency", lat, c_W - 1);
        start    = 1'b1;
        dividend = 4'd3;
        divisor  = 4'd2;
        sb.push_back(model(4'd3, 4'd2));
        @(posedge clk);
        #1;
        start = 1'b0;
        check("done_cycle_accept_busy", int'(busy), 1);
        wait_done(lat, bcnt);
        check("done_cycle_accept_latency", lat, c_W + 1);

        // Reset in the middle of an operation aborts it
        @(negedge clk);
        start    = 1'b1;
        dividend = 4'd7;
        divisor  = 4'd2;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_busy", int'(busy), 0);
        check("abort_outputs", int'({quotient, remainder}), 0);
        check("abort_flags", int'({done, div_by_zero, overflow}), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        bcnt = 0;
        for (int n = 0; n < 8; n++) begin
            @(posedge clk);
            #1;
            if (done) bcnt++;
        end
        check("abort_no_done", bcnt, 0);
        run_op(4'd7, 4'd2, model(4'd7, 4'd2), c_W + 1);

        // Exhaustive sweep against the integer reference
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                logic [c_W-1:0] va;
                logic [c_W-1:0] vb;
                va = c_W'(a);
                vb = c_W'(b);
                run_op(va, vb, model(va, vb), (b == 0) ? 1 : c_W + 1);
            end
        end

        repeat (3) @(posedge clk);
        check("scoreboard_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
